pulse_burst_capture: RTL and testbench
======================================

// Module: pulse_burst_capture
// PURPOSE
// - Sits directly downstream of the pulse generator; consumes its period counter (cnt) and gate (dout).
// - On every pulse period, waits a programmable delay after cnt==0, then captures a burst of ADC samples.
// - Buffers each burst atomically and streams it out on AXI4-Stream toward DMA, with tlast on the last sample.
// - Bursts that do not fit in the buffer are skipped whole and counted.
// PARAMETERS
// - DATA_WIDTH    16  ADC sample width.
// - CNT_WIDTH     16  Width of pulse_cnt and delay; equals the generator's period width.
// - DEPTH_LOG2    10  Buffer depth = 2**DEPTH_LOG2 samples.
// PORTS
// - clk           in   1            Single clock domain; ADC, generator and AXIS are all on clk.
// - resetn        in   1            Asynchronous active-low reset.
// - enable        in   1            Arms capture when high.
// - pulse_cnt     in   CNT_WIDTH    Generator period counter; 0 marks period start.
// - pulse_in      in   1            Generator gate; used only for the gate_mode qualifier.
// - gate_mode     in   1            1: a sample is written only while pulse_in is high.
// - delay         in   CNT_WIDTH    Trigger when pulse_cnt == delay.
// - n_samples     in   DEPTH_LOG2+1 Samples per burst (0 = no capture).
// - adc_data      in   DATA_WIDTH   ADC sample, valid every cycle.
// - m_axis_tdata  out  DATA_WIDTH   Streamed sample.
// - m_axis_tvalid out  1            Stream valid.
// - m_axis_tready in   1            Stream ready.
// - m_axis_tlast  out  1            High on the last sample of each burst.
// - busy          out  1            High while in CAPTURE.
// - burst_count   out  32           Bursts fully written to the buffer; wraps at 2**32.
// - skip_count    out  32           Bursts skipped for lack of space; wraps at 2**32.
// BEHAVIOUR
// - Reset values: all outputs 0, buffer empty, FSM in IDLE.
// - Reset mid-burst flushes the buffer; a partial burst is never emitted.
// - FSM states:
//   - IDLE: move to ARMED when enable=1.
//   - ARMED: on the trigger cycle (pulse_cnt==delay and n_samples!=0):
//     - latch n_samples into len_reg;
//     - if free space >= n_samples, go to CAPTURE, else skip_count++ and stay in ARMED;
//     - if enable=0, return to IDLE.
//   - CAPTURE: write one sample per cycle (only where pulse_in=1 when gate_mode=1), starting with the
//     adc_data present on the trigger cycle itself.
//     - After len_reg writes: burst_count++ and go to ARMED, or to IDLE if enable=0.
//     - Deasserting enable mid-burst does not abort the burst.
// - Free space counts committed writes, including any write registered in the same cycle.
//   A burst, once started, therefore never overflows.
// - Triggers seen while in CAPTURE are ignored; each period starts at most one burst.
// - pulse_cnt wraps to 0 mid-capture: the burst continues across the wrap.
// - delay >= the generator period: no trigger ever fires; this is not an error.
// - Stored word = {last_flag, sample}; last_flag is set on write index len_reg-1.
// - Output is first-word-fall-through.
//   - Latency: first sample appears on m_axis_tvalid 2 cycles after the trigger cycle.
//   - Standard AXIS handshake: transfer when tvalid & tready.
//   - tdata/tlast stay stable while tvalid=1 and tready=0.
// - Buffer full and read-and-write in the same cycle: both proceed, occupancy is unchanged.
// - Buffer empty: tvalid=0.
// - Pointers are DEPTH_LOG2 bits and wrap naturally; occupancy is DEPTH_LOG2+1 bits.
// - n_samples > 2**DEPTH_LOG2: every burst is skipped.
// STRUCTURE
// - Shared package pulse_pkg:
//   - FSM state encoding IDLE/ARMED/CAPTURE as localparams;
//   - default CNT_WIDTH, shared with the pulse generator.
// - Sub-module sync_fifo_fwft (width DATA_WIDTH+1, depth 2**DEPTH_LOG2):
//   - ports: wr_en, din, rd_en, dout, empty, level.
// - Top level holds the FSM, trigger compare, counters and the AXIS mapping.
// TESTING
// - delay=5, n_samples=4, adc_data=ramp, tready=1:
//   - samples captured at pulse_cnt 5..8;
//   - tvalid first high 2 cycles after pulse_cnt==5;
//   - tlast on the 4th sample; burst_count=1.
// - tready=0 with DEPTH_LOG2=4, n_samples=6:
//   - bursts 1 and 2 stored; burst 3 skipped, skip_count=1;
//   - release tready: exactly 12 words out, tlast on words 6 and 12.
// - gate_mode=1, pulse_width=3, delay=0, n_samples=6:
//   - only the 3 gated samples written per period; the burst spans 2 periods;
//   - tlast on the 6th written sample.
// - Drop enable mid-CAPTURE: burst completes with tlast; FSM reaches IDLE; no further triggers.
// - Assert resetn=0 mid-burst with 3 words buffered:
//   - tvalid=0 immediately; counters 0; after release, the next burst streams intact.
// - Random tready throttling over 100 bursts: data matches the model, no loss, tdata stable while stalled.

Source files
------------

// File: rtl/pulse_burst_capture_pkg.sv
// Shared definitions for the pulse generator / burst capture pair.
// FSM encoding and the common period-counter width.
package pulse_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

endpackage

// File: rtl/pulse_burst_capture_fifo.sv
// First-word-fall-through synchronous FIFO for captured burst words.
// Head word is presented combinationally whenever the FIFO is non-empty.
module sync_fifo_fwft #(
  parameter int W          = 17,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [W-1:0]          din,
  input  logic                  rd_en,
  output logic [W-1:0]          dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LW-1:0]         r_level;

  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  assign w_full  = (r_level == FULL_LVL);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign w_do_rd = rd_en && !empty;
  // A full FIFO still accepts a write when a read frees a slot this cycle.
  assign w_do_wr = wr_en && (!w_full || w_do_rd);
  assign dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pulse_burst_capture.sv
// Delayed burst capture of ADC samples per pulse period, buffered whole
// and streamed out on AXI4-Stream with tlast on each burst's final word.
module pulse_burst_capture
  import pulse_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  pulse_cnt,
  input  logic                  pulse_in,
  input  logic                  gate_mode,
  input  logic [CNT_WIDTH-1:0]  delay,
  input  logic [DEPTH_LOG2:0]   n_samples,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [31:0]           burst_count,
  output logic [31:0]           skip_count
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam int FW = DATA_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_W = LW'(2 ** DEPTH_LOG2);

  state_t r_state;
  state_t w_next;

  logic w_trig;
  logic w_gate;
  logic w_fits;
  logic w_start;
  logic w_skip;
  logic w_wr;
  logic w_last;
  logic w_done;
  logic w_busy;

  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] w_len;
  logic [LW-1:0] w_idx;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_free;

  logic          r_wr_en;
  logic [FW-1:0] r_wr_data;
  logic [FW-1:0] w_rd_data;
  logic          w_empty;
  logic          w_rd_en;

  logic [31:0] r_burst_cnt;
  logic [31:0] r_skip_cnt;

  assign w_trig = (pulse_cnt == delay)
               && (n_samples != '0);
  assign w_gate = !gate_mode || pulse_in;

  // The staged write is already committed, so it counts against space.
  assign w_free = DEPTH_W - w_level
                - LW'(r_wr_en);
  assign w_fits = (n_samples <= w_free);

  assign w_len = (r_state == ST_ARMED)
               ? n_samples : r_len;
  assign w_idx = (r_state == ST_ARMED)
               ? '0 : r_idx;

  assign w_last = (w_idx == (w_len - LW'(1)));
  assign w_done = w_wr && w_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (enable) begin
          w_next = ST_ARMED;
        end
      end
      (r_state == ST_ARMED): begin
        if (!enable) begin
          w_next = ST_IDLE;
        end else if (w_start && !w_done) begin
          w_next = ST_CAPTURE;
        end
      end
      (r_state == ST_CAPTURE): begin
        if (w_done) begin
          w_next = enable ? ST_ARMED : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_start = 1'b0;
    w_skip  = 1'b0;
    w_wr    = 1'b0;
    unique case (1'b1)
      (r_state == ST_ARMED): begin
        if (enable && w_trig) begin
          if (w_fits) begin
            w_start = 1'b1;
            w_wr    = w_gate;
          end else begin
            w_skip = 1'b1;
          end
        end
      end
      (r_state == ST_CAPTURE): begin
        w_busy = 1'b1;
        w_wr   = w_gate;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_burst_cnt <= '0;
      r_skip_cnt  <= '0;
    end else begin
      if (w_start || w_skip) begin
        r_len <= n_samples;
      end
      if (w_start) begin
        r_idx <= w_wr ? LW'(1) : '0;
      end else if (w_busy && w_wr) begin
        r_idx <= r_idx + LW'(1);
      end
      // One-stage write pipeline gives the two-cycle trigger latency.
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_data <= {w_last, adc_data};
      end
      if (w_done) begin
        r_burst_cnt <= r_burst_cnt + 32'd1;
      end
      if (w_skip) begin
        r_skip_cnt <= r_skip_cnt + 32'd1;
      end
    end
  end

  sync_fifo_fwft #(
    .W          (FW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (r_wr_en),
    .din    (r_wr_data),
    .rd_en  (w_rd_en),
    .dout   (w_rd_data),
    .empty  (w_empty),
    .level  (w_level)
  );

  assign w_rd_en = m_axis_tready && !w_empty;

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0
                       : w_rd_data[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !w_empty
                       && w_rd_data[DATA_WIDTH];

  assign busy        = w_busy;
  assign burst_count = r_burst_cnt;
  assign skip_count  = r_skip_cnt;

endmodule

// File: tb/tb_pulse_burst_capture.sv
// Directed bench for pulse_burst_capture with a 16-deep buffer.
// Models the pulse generator; adc_data equals the global cycle index.
module tb_pulse_burst_capture;

  localparam int DL = 4;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [15:0] pulse_cnt;
  logic        pulse_in;
  logic        gate_mode;
  logic [15:0] delay;
  logic [DL:0] n_samples;
  logic [15:0] adc_data;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        busy;
  logic [31:0] burst_count;
  logic [31:0] skip_count;

  pulse_burst_capture #(
    .DATA_WIDTH (16),
    .CNT_WIDTH  (16),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .pulse_cnt     (pulse_cnt),
    .pulse_in      (pulse_in),
    .gate_mode     (gate_mode),
    .delay         (delay),
    .n_samples     (n_samples),
    .adc_data      (adc_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .burst_count   (burst_count),
    .skip_count    (skip_count)
  );

  typedef struct {
    int period;
    int width;
    int gate;
    int dly;
    int n;
    int ticks;
    int hold;
    int first;
    int run;
    int bursts;
    int skips;
    int words;
  } vec_t;

  vec_t tbl[9];

  int n_cmp = 0;
  int n_err = 0;
  int g;
  int period;
  int width;

  logic [16:0] rx[$];
  logic        stall;
  logic [16:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, exp);
    end
  endtask

  task automatic gen();
    int c;
    c = g % period;
    pulse_cnt = 16'(c);
    pulse_in  = (c < width);
    adc_data  = 16'(g);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    g++;
    gen();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    g = 0;
    gen();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rx.delete();
  endtask

  // Collects transfers and checks the head word holds while stalled.
  always @(negedge clk) begin
    if (!resetn) begin
      stall <= 1'b0;
    end else begin
      if (stall) begin
        chk("stall tvalid", 32'(tvalid), 32'd1);
        chk("stall word", 32'({tlast, tdata}),
            32'(held));
      end
      if (tvalid && tready) begin
        rx.push_back({tlast, tdata});
      end
      stall <= tvalid && !tready;
      held  <= {tlast, tdata};
    end
  end

  initial begin
    int ne;
    int base;
    tbl[0] = '{20, 20, 0, 5, 4, 24, 0, 5, 4, 1, 0, 4};
    tbl[1] = '{20, 20, 0, 5, 6, 64, 1, 5, 6, 2, 1, 12};
    tbl[2] = '{10, 3, 1, 0, 6, 28, 0, 10, 3, 1, 0, 6};
    tbl[3] = '{10, 10, 0, 3, 0, 40, 0, 0, 1, 0, 0, 0};
    tbl[4] = '{20, 20, 0, 2, 17, 44, 0, 0, 1, 0, 3, 0};
    tbl[5] = '{10, 10, 0, 10, 4, 40, 0, 0, 1, 0, 0, 0};
    tbl[6] = '{8, 8, 0, 6, 5, 13, 0, 6, 5, 1, 0, 5};
    tbl[7] = '{10, 10, 0, 4, 1, 26, 0, 4, 1, 3, 0, 3};
    tbl[8] = '{40, 40, 0, 3, 16, 38, 1, 3, 16, 1, 0, 16};

    stall = 1'b0;
    held = '0;
    period = 20;
    width = 20;
    g = 0;
    gen();
    enable = 1'b0;
    gate_mode = 1'b0;
    delay = 16'd5;
    n_samples = 5'd4;
    tready = 1'b1;

    // Reset values
    resetn = 1'b0;
    #12;
    chk("rst tvalid", 32'(tvalid), 32'd0);
    chk("rst tdata", 32'(tdata), 32'd0);
    chk("rst tlast", 32'(tlast), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bursts", burst_count, 32'd0);
    chk("rst skips", skip_count, 32'd0);

    for (int v = 0; v < 9; v++) begin
      period    = tbl[v].period;
      width     = tbl[v].width;
      gate_mode = (tbl[v].gate != 0);
      delay     = 16'(tbl[v].dly);
      n_samples = 5'(tbl[v].n);
      tready    = (tbl[v].hold == 0);
      enable    = 1'b1;
      do_reset();
      repeat (tbl[v].ticks) tick();
      enable = 1'b0;
      tready = 1'b1;
      repeat (40) tick();
      chk($sformatf("v%0d bursts", v),
          burst_count, 32'(tbl[v].bursts));
      chk($sformatf("v%0d skips", v),
          skip_count, 32'(tbl[v].skips));
      chk($sformatf("v%0d words", v),
          32'(rx.size()), 32'(tbl[v].words));
      ne = (tbl[v].n > 0) ? tbl[v].n : 1;
      for (int i = 0; i < rx.size(); i++) begin
        chk($sformatf("v%0d data[%0d]", v, i),
            32'(rx[i][15:0]),
            32'(tbl[v].first
                + (i / tbl[v].run) * tbl[v].period
                + (i % tbl[v].run)));
        chk($sformatf("v%0d last[%0d]", v, i),
            32'(rx[i][16]),
            32'((i % ne) == ne - 1));
      end
    end

    // Trigger-to-tvalid latency and busy window
    period = 20; width = 20;
    gate_mode = 1'b0;
    delay = 16'd5;
    n_samples = 5'd4;
    tready = 1'b1;
    enable = 1'b1;
    do_reset();
    repeat (6) tick();
    chk("lat tvalid@T+1", 32'(tvalid), 32'd0);
    chk("lat busy@T+1", 32'(busy), 32'd1);
    tick();
    chk("lat tvalid@T+2", 32'(tvalid), 32'd1);
    chk("lat tdata@T+2", 32'(tdata), 32'd5);
    repeat (2) tick();
    chk("lat busy end", 32'(busy), 32'd0);
    enable = 1'b0;
    repeat (20) tick();
    chk("lat words", 32'(rx.size()), 32'd4);

    // Enable dropped during CAPTURE
    n_samples = 5'd6;
    enable = 1'b1;
    do_reset();
    repeat (7) tick();
    chk("en busy mid", 32'(busy), 32'd1);
    enable = 1'b0;
    repeat (40) tick();
    chk("en busy idle", 32'(busy), 32'd0);
    chk("en bursts", burst_count, 32'd1);
    chk("en words", 32'(rx.size()), 32'd6);
    if (rx.size() == 6) begin
      chk("en last word", 32'(rx[5]),
          32'({1'b1, 16'd10}));
    end

    // Reset with three words buffered
    tready = 1'b0;
    enable = 1'b1;
    do_reset();
    repeat (9) tick();
    chk("rb busy", 32'(busy), 32'd1);
    chk("rb tvalid", 32'(tvalid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rb tvalid rst", 32'(tvalid), 32'd0);
    chk("rb bursts rst", burst_count, 32'd0);
    chk("rb skips rst", skip_count, 32'd0);
    chk("rb busy rst", 32'(busy), 32'd0);
    tready = 1'b1;
    do_reset();
    repeat (24) tick();
    enable = 1'b0;
    repeat (20) tick();
    chk("rb bursts", burst_count, 32'd1);
    chk("rb words", 32'(rx.size()), 32'd6);
    for (int i = 0; i < rx.size(); i++) begin
      chk($sformatf("rb word[%0d]", i), 32'(rx[i]),
          32'({1'(i == 5), 16'(5 + i)}));
    end

    // 100 bursts under random backpressure
    period = 12; width = 12;
    delay = 16'd2;
    n_samples = 5'd5;
    enable = 1'b1;
    tready = 1'b1;
    do_reset();
    for (int t = 0; t < 1196; t++) begin
      tready = ($urandom_range(3, 0) != 0);
      tick();
    end
    enable = 1'b0;
    tready = 1'b1;
    repeat (40) tick();
    chk("rnd total", burst_count + skip_count,
        32'd100);
    chk("rnd words", 32'(rx.size()),
        burst_count * 32'd5);
    base = 0;
    for (int i = 0; i < rx.size(); i++) begin
      if (i % 5 == 0) begin
        base = int'(rx[i][15:0]);
        chk("rnd start", 32'(base % 12), 32'd2);
      end else begin
        chk("rnd data", 32'(rx[i][15:0]),
            32'(base + i % 5));
      end
      chk("rnd last", 32'(rx[i][16]),
          32'(i % 5 == 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
